// File: rtl/i2c_master_engine_if.sv
// Host-side command/status bundle for i2c_master_engine.
// master = command issuer (host), slave = the engine itself.
interface i2c_master_engine_if #(
  parameter int unsigned CTR_W  = 16,
  parameter int unsigned DATA_W = 8
);
  logic [2:0]        cmd;
  logic              wr_i2c;
  logic [DATA_W-1:0] din;
  logic [CTR_W-1:0]  dvsr;
  logic              ready;
  logic              done_tick;
  logic              ack;
  logic [DATA_W-1:0] dout;

  modport master (
    output cmd, wr_i2c, din, dvsr,
    input  ready, done_tick, ack, dout
  );

  modport slave (
    input  cmd, wr_i2c, din, dvsr,
    output ready, done_tick, ack, dout
  );
endinterface

// File: rtl/i2c_master_engine.sv
// I2C master bit/byte engine: START/WRITE/READ/RESTART/STOP with a runtime quarter-period divider.
// Optional slave clock stretching is enabled by defining I2C_CLK_STRETCH_EN.
module i2c_master_engine #(
  parameter int unsigned CTR_W  = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  i2c_master_engine_if.slave host,
  input  logic              sda_in,
  input  logic              scl_in,
  output logic              sda_out,
  output logic              scl_out
);

  localparam int unsigned BIT_W = $clog2(DATA_W + 2);

  localparam logic [2:0] CMD_START   = 3'd0;
  localparam logic [2:0] CMD_WRITE   = 3'd1;
  localparam logic [2:0] CMD_READ    = 3'd2;
  localparam logic [2:0] CMD_STOP    = 3'd3;
  localparam logic [2:0] CMD_RESTART = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_START1, S_START2, S_HOLD,
    S_DATA1, S_DATA2, S_DATA3, S_DATA4, S_DATA_END,
    S_RESTART, S_STOP1, S_STOP2
  } state_t;

  state_t           state_reg;
  state_t           timed_next;
  logic [CTR_W-1:0] ctr_reg;
  logic [BIT_W-1:0] bit_reg;
  logic [DATA_W:0]  tx_reg;
  logic [DATA_W:0]  rx_reg;
  logic             is_read_reg;
  logic             accept;
  logic             stall;
  logic             phase_end;
  logic             last_bit;
  logic             sda_c;
  logic             scl_c;

  assign accept    = host.wr_i2c & host.ready;
  assign last_bit  = (bit_reg == BIT_W'(DATA_W));
  assign phase_end = (ctr_reg == host.dvsr) && !stall;

`ifdef I2C_CLK_STRETCH_EN
  // A slave holding SCL low while we release it freezes the high phases.
  always_comb begin
    stall = 1'b0;
    if (scl_out && !scl_in) begin
      case (state_reg)
        S_DATA2, S_DATA3, S_STOP1, S_STOP2: stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign stall         = 1'b0;
`endif

  // Successor of each quarter-period-timed state.
  always_comb begin
    timed_next = S_IDLE;
    case (state_reg)
      S_START1:  timed_next = S_START2;
      S_START2:  timed_next = S_HOLD;
      S_DATA1:   timed_next = S_DATA2;
      S_DATA2:   timed_next = S_DATA3;
      S_DATA3:   timed_next = S_DATA4;
      S_DATA4:   timed_next = last_bit ? S_DATA_END : S_DATA1;
      S_RESTART: timed_next = S_START1;
      S_STOP1:   timed_next = S_STOP2;
      S_STOP2:   timed_next = S_IDLE;
      default:   timed_next = S_IDLE;
    endcase
  end

  // Line levels for the current state; registered below so pads lag state by one cycle.
  always_comb begin
    sda_c = 1'b0;
    scl_c = 1'b0;
    case (state_reg)
      S_IDLE:                             begin sda_c = 1'b1;           scl_c = 1'b1; end
      S_START1:                           begin sda_c = 1'b0;           scl_c = 1'b1; end
      S_START2, S_HOLD, S_DATA_END:       begin sda_c = 1'b0;           scl_c = 1'b0; end
      S_DATA1, S_DATA4:                   begin sda_c = tx_reg[DATA_W]; scl_c = 1'b0; end
      S_DATA2, S_DATA3:                   begin sda_c = tx_reg[DATA_W]; scl_c = 1'b1; end
      S_RESTART:                          begin sda_c = 1'b1;           scl_c = 1'b0; end
      S_STOP1:                            begin sda_c = 1'b0;           scl_c = 1'b1; end
      S_STOP2:                            begin sda_c = 1'b1;           scl_c = 1'b1; end
      default:                            begin sda_c = 1'b1;           scl_c = 1'b1; end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      ctr_reg        <= '0;
      bit_reg        <= '0;
      tx_reg         <= '1;
      rx_reg         <= '0;
      is_read_reg    <= 1'b0;
      sda_out        <= 1'b1;
      scl_out        <= 1'b1;
      host.ready     <= 1'b1;
      host.done_tick <= 1'b0;
      host.ack       <= 1'b1;
      host.dout      <= '0;
    end else begin
      host.done_tick <= 1'b0;
      sda_out        <= sda_c;
      scl_out        <= scl_c;
      case (state_reg)
        S_IDLE: begin
          if (accept && host.cmd == CMD_START) begin
            ctr_reg    <= '0;
            state_reg  <= S_START1;
            host.ready <= 1'b0;
          end else begin
            ctr_reg <= ctr_reg + CTR_W'(1);
          end
        end
        S_HOLD: begin
          if (accept) begin
            case (host.cmd)
              CMD_WRITE, CMD_READ: begin
                state_reg   <= S_DATA1;
                host.ready  <= 1'b0;
                bit_reg     <= '0;
                is_read_reg <= (host.cmd == CMD_READ);
                // READ releases SDA for the data bits and sends din[0] as the master ACK.
                tx_reg      <= (host.cmd == CMD_READ) ? {{DATA_W{1'b1}}, host.din[0]}
                                                      : {host.din, 1'b1};
              end
              CMD_RESTART: begin
                state_reg  <= S_RESTART;
                host.ready <= 1'b0;
              end
              CMD_STOP: begin
                state_reg  <= S_STOP1;
                host.ready <= 1'b0;
              end
              default: state_reg <= S_HOLD;
            endcase
            ctr_reg <= '0;
          end
        end
        S_DATA_END: begin
          state_reg  <= S_HOLD;
          host.ready <= 1'b1;
        end
        default: begin
          if (phase_end) begin
            ctr_reg   <= '0;
            state_reg <= timed_next;
            if (state_reg == S_DATA2) begin
              rx_reg <= {rx_reg[DATA_W-1:0], sda_in};
            end
            if (state_reg == S_DATA4) begin
              tx_reg  <= {tx_reg[DATA_W-1:0], 1'b1};
              bit_reg <= bit_reg + BIT_W'(1);
              if (last_bit) begin
                host.done_tick <= 1'b1;
                if (is_read_reg) begin
                  host.dout <= rx_reg[DATA_W:1];
                end else begin
                  host.ack <= rx_reg[0];
                end
              end
            end
            if (timed_next == S_HOLD || timed_next == S_IDLE) begin
              host.ready <= 1'b1;
            end
          end else if (!stall) begin
            ctr_reg <= ctr_reg + CTR_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_engine.sv
// Directed scoreboard bench for i2c_master_engine (wired-AND bus with a simple slave model).
module tb_i2c_master_engine;

  localparam int unsigned CTR_W  = 16;
  localparam int unsigned DATA_W = 8;

  localparam logic [2:0] C_START   = 3'd0;
  localparam logic [2:0] C_WRITE   = 3'd1;
  localparam logic [2:0] C_READ    = 3'd2;
  localparam logic [2:0] C_STOP    = 3'd3;
  localparam logic [2:0] C_RESTART = 3'd4;

`ifdef I2C_CLK_STRETCH_EN
  localparam int STRETCH_LAT = 154;
`else
  localparam int STRETCH_LAT = 144;
`endif

  typedef struct {
    logic [7:0] data;
    logic       ack;
    int         lat;
    logic [8:0] bits;
  } exp_t;

  logic clk        = 1'b0;
  logic reset      = 1'b1;
  logic slv_sda    = 1'b1;
  logic stretch_on = 1'b0;
  logic sda_in, scl_in, sda_out, scl_out;

  int checks = 0;
  int errors = 0;

  logic       model_ack  = 1'b1;
  logic [7:0] model_dout = 8'h00;
  exp_t       sb[$];

  i2c_master_engine_if #(.CTR_W(CTR_W), .DATA_W(DATA_W)) hif ();

  i2c_master_engine #(.CTR_W(CTR_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .host    (hif),
    .sda_in  (sda_in),
    .scl_in  (scl_in),
    .sda_out (sda_out),
    .scl_out (scl_out)
  );

  assign sda_in = sda_out & slv_sda;
  assign scl_in = scl_out & ~stretch_on;

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a strobe at a negedge; returns at the next negedge (first sample after acceptance).
  task automatic issue(input logic [2:0] c, input logic [7:0] d);
    hif.cmd    = c;
    hif.din    = d;
    hif.wr_i2c = 1'b1;
    @(negedge clk);
    hif.wr_i2c = 1'b0;
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  // One WRITE/READ byte: push expectation, run slave model, pop and compare at done_tick.
  task automatic xfer(input logic rd, input logic [7:0] d, input logic [7:0] slv_byte,
                      input logic slv_ack, input logic do_stretch, input int exp_lat);
    exp_t       e;
    exp_t       got_e;
    int         n;
    int         rises;
    int         stretch_left;
    logic       prev_scl;
    logic [8:0] bits;
    logic       got;
    e.lat  = exp_lat;
    e.ack  = rd ? model_ack : slv_ack;
    e.data = rd ? slv_byte : model_dout;
    e.bits = rd ? {8'hFF, d[0]} : {d, 1'b1};
    model_ack  = e.ack;
    model_dout = e.data;
    sb.push_back(e);
    issue(rd ? C_READ : C_WRITE, d);
    hif.din = ~d;
    chk1("busy_ready", hif.ready, 1'b0);
    n = 0; rises = 0; stretch_left = 0; bits = '0; got = 1'b0;
    prev_scl = scl_out;
    while (n < 400) begin
      if (hif.done_tick === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (scl_out && !prev_scl) begin
        bits  = {bits[7:0], sda_out};
        rises++;
        if (do_stretch && rises == 3) begin
          stretch_on   = 1'b1;
          stretch_left = 11;
        end
      end
      prev_scl = scl_out;
      if (stretch_left > 0) begin
        stretch_left--;
        if (stretch_left == 0) stretch_on = 1'b0;
      end
      if (!scl_out) begin
        if (rises < 8)       slv_sda = rd ? slv_byte[7 - rises] : 1'b1;
        else if (rises == 8) slv_sda = rd ? 1'b1 : slv_ack;
        else                 slv_sda = 1'b1;
      end
      if (n == 20) begin hif.cmd = C_STOP; hif.wr_i2c = 1'b1; end
      if (n == 21) hif.wr_i2c = 1'b0;
      @(negedge clk);
      n++;
    end
    slv_sda    = 1'b1;
    stretch_on = 1'b0;
    chk1("done_seen", got, 1'b1);
    if (got) begin
      got_e = sb.pop_front();
      chkw("latency", 32'(n), 32'(got_e.lat));
      chk1("ack", hif.ack, got_e.ack);
      chkw("dout", 32'(hif.dout), 32'(got_e.data));
      chkw("sda_bits", 32'(bits), 32'(got_e.bits));
      step(1);
      chk1("done_pulse_end", hif.done_tick, 1'b0);
      chk1("hold_ready", hif.ready, 1'b1);
    end
  endtask

  initial begin
    hif.cmd    = C_START;
    hif.wr_i2c = 1'b0;
    hif.din    = 8'h00;
    hif.dvsr   = 16'd3;

    // Reset values
    step(2);
    chk1("rst_ready", hif.ready, 1'b1);
    chk1("rst_sda", sda_out, 1'b1);
    chk1("rst_scl", scl_out, 1'b1);
    chk1("rst_done", hif.done_tick, 1'b0);
    chk1("rst_ack", hif.ack, 1'b1);
    chkw("rst_dout", 32'(hif.dout), 32'h0);
    chkw("rst_ctr", 32'(dut.ctr_reg), 32'h0);
    reset = 1'b0;

    // Idle counter free-runs
    for (int i = 1; i <= 4; i++) begin
      step(1);
      chkw("idle_ctr", 32'(dut.ctr_reg), 32'(i));
    end

    // Non-START commands ignored in idle
    issue(C_RESTART, 8'h00);
    chkw("idle_restart_ctr", 32'(dut.ctr_reg), 32'd5);
    issue(C_STOP, 8'h00);
    chkw("idle_stop_ctr", 32'(dut.ctr_reg), 32'd6);
    issue(C_READ, 8'h01);
    chkw("idle_read_ctr", 32'(dut.ctr_reg), 32'd7);
    issue(C_WRITE, 8'hA5);
    chkw("idle_write_ctr", 32'(dut.ctr_reg), 32'd8);
    chk1("idle_ready", hif.ready, 1'b1);
    chk1("idle_sda", sda_out, 1'b1);

    // START sequence
    issue(C_START, 8'h00);
    chkw("start_ctr0", 32'(dut.ctr_reg), 32'h0);
    chk1("start_ready0", hif.ready, 1'b0);
    chk1("start_sda_lag", sda_out, 1'b1);
    step(1);
    chk1("start_sda", sda_out, 1'b0);
    chk1("start_scl", scl_out, 1'b1);
    step(6);
    chk1("start_ready7", hif.ready, 1'b0);
    step(1);
    chk1("start_ready8", hif.ready, 1'b1);

    // WRITE 0xA5 with slave ACK, READ 0x3C with master NACK
    xfer(1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 144);
    xfer(1'b1, 8'h01, 8'h3C, 1'b1, 1'b0, 144);

    // STOP: SDA rises while SCL high
    issue(C_STOP, 8'h00);
    step(4);
    chk1("stop1_sda", sda_out, 1'b0);
    chk1("stop1_scl", scl_out, 1'b1);
    step(1);
    chk1("stop2_sda", sda_out, 1'b1);
    chk1("stop2_scl", scl_out, 1'b1);
    step(2);
    chk1("stop_ready7", hif.ready, 1'b0);
    step(1);
    chk1("stop_ready8", hif.ready, 1'b1);

    // New START; START and no-op commands are ignored in hold
    issue(C_START, 8'h00);
    step(8);
    chk1("start2_ready", hif.ready, 1'b1);
    issue(C_START, 8'h00);
    chk1("hold_start_ready", hif.ready, 1'b1);
    issue(3'd7, 8'h00);
    chk1("hold_noop_ready", hif.ready, 1'b1);
    chk1("hold_sda", sda_out, 1'b0);
    chk1("hold_scl", scl_out, 1'b0);

    // dvsr=0 (one-cycle quarter period), slave NACK
    hif.dvsr = 16'd0;
    xfer(1'b0, 8'h5A, 8'h00, 1'b1, 1'b0, 36);
    hif.dvsr = 16'd3;

    // Stretched WRITE (stretch only effective with the feature compiled in)
    xfer(1'b0, 8'hC3, 8'h00, 1'b0, 1'b1, STRETCH_LAT);

    // RESTART back into hold
    issue(C_RESTART, 8'h00);
    step(1);
    chk1("restart_sda", sda_out, 1'b1);
    chk1("restart_scl", scl_out, 1'b0);
    step(10);
    chk1("restart_ready11", hif.ready, 1'b0);
    step(1);
    chk1("restart_ready12", hif.ready, 1'b1);

    // Reset mid-transfer releases lines immediately
    issue(C_WRITE, 8'h00);
    step(10);
    reset = 1'b1;
    #1;
    chk1("midrst_sda", sda_out, 1'b1);
    chk1("midrst_scl", scl_out, 1'b1);
    chk1("midrst_ready", hif.ready, 1'b1);
    chk1("midrst_ack", hif.ack, 1'b1);
    chkw("midrst_dout", 32'(hif.dout), 32'h0);
    step(1);
    reset = 1'b0;
    chkw("sb_empty", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master_engine.md
Name: i2c_master_engine

Overview:
- Parametrised I2C master bit/byte engine; successor to the fixed 16-bit idle-state next-state logic.
- Full command FSM (start, write, read, restart, stop) with runtime quarter-period divider and open-drain line control.
- Sits between the host command interface and the SCL/SDA pad drivers.
- Optional slave clock-stretching support.

Parameters:
- CTR_W, 16, width of phase counter and dvsr input
- DATA_W, 8, bits per transfer (ACK bit added as bit DATA_W+1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd  in  3  command: START=0, WRITE=1, READ=2, STOP=3, RESTART=4; 5..7 treated as no-op
- wr_i2c  in  1  command strobe; accepted only when wr_i2c & ready
- din  in  DATA_W  WRITE: data, MSB first; READ: din[0] is the master ACK bit to send
- dvsr  in  CTR_W  quarter-period length minus 1; must be held stable while ready=0
- sda_in  in  1  sampled SDA line
- scl_in  in  1  sampled SCL line; used only with the optional feature
- sda_out  out  1  1 = release SDA, 0 = pull low; registered
- scl_out  out  1  1 = release SCL, 0 = pull low; registered
- ready  out  1  high in idle and hold
- done_tick  out  1  one-cycle pulse at end of a WRITE/READ byte
- ack  out  1  ACK bit sampled in the 9th slot of a WRITE (0 = ACK)
- dout  out  DATA_W  READ data; valid from done_tick until the next accepted READ

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: state=idle, ctr=0, sda_out=1, scl_out=1, ready=1, done_tick=0, ack=1, dout=0, bit counter=0.
- Quarter period: Q = dvsr+1 cycles. The phase ends when ctr_reg==dvsr; ctr then returns to 0. dvsr=0 is legal (Q=1). CTR_W-bit counter wraps modulo 2^CTR_W.
- States (each lasts Q unless noted):
  - idle
  - start1 (SDA 0, SCL 1)
  - start2 (SDA 0, SCL 0)
  - hold (SDA 0, SCL 0; no timeout)
  - data1 (SCL 0, SDA set up)
  - data2, data3 (SCL 1)
  - data4 (SCL 0)
  - data_end (SCL 0; one cycle)
  - restart (SDA 1, SCL 0)
  - stop1 (SDA 0, SCL 1)
  - stop2 (SDA 1, SCL 1)
- idle:
  - ctr_next = ctr_reg+1 (free-running).
  - Accepted START: ctr_next=0, state_next=start1.
  - Any other command: ignored; stays idle and ctr keeps incrementing.
- start1 -> start2 -> hold.
- hold, accepted command:
  - WRITE/READ -> data1, bit counter=0.
  - RESTART -> restart -> start1.
  - STOP -> stop1 -> stop2 -> idle.
  - START -> ignored, stays hold.
- Data bit: data1 -> data2 -> data3 -> data4, repeated for DATA_W+1 bits.
  - sda_in is sampled at the end of data2.
  - After bit DATA_W+1 completes data4: data_end, assert done_tick, then hold.
- WRITE:
  - Bits 1..DATA_W drive din MSB first.
  - Bit DATA_W+1 releases SDA; the sampled value goes to ack.
- READ:
  - Bits 1..DATA_W release SDA; sampled values shift into dout MSB first.
  - Bit DATA_W+1 drives din[0]. ack is unchanged.
- din and cmd are captured on acceptance; later changes have no effect.
- wr_i2c while ready=0 is ignored (no queueing).
- sda_out/scl_out are registered and lag the state by one cycle.
- Reset asserted mid-transfer: immediate return to idle with lines released. No STOP is generated.

Optional Feature:
- Macro: I2C_CLK_STRETCH_EN.
- Defined:
  - In data2/data3/stop1/stop2, ctr holds at its value while scl_out=1 and scl_in=0 (slave stretching).
  - The phase resumes when scl_in=1, so phase length becomes Q + stretch cycles.
- Undefined: scl_in is ignored and all phases are exactly Q.

Test Plan:
1. Reset, dvsr=3, no command -> ready=1, sda_out=scl_out=1, ctr increments by 1 each clk.
2. In idle, issue RESTART, STOP, READ, WRITE in turn -> state stays idle, ready=1, ctr=previous+1 each cycle.
3. START, dvsr=3 -> start1 next cycle, sda_out=0 one cycle later, ready=1 (hold) after 8 cycles; ctr=0 on entry to start1.
4. WRITE din=0xA5, sda_in held 0 during 9th bit -> SDA pattern 1,0,1,0,0,1,0,1,release; done_tick single pulse 144 cycles (36Q) after acceptance; ack=0.
5. READ din[0]=1, slave returns 0x3C -> dout=0x3C at done_tick; sda_out=1 (NACK) during 9th bit; then STOP -> SDA rises while SCL high, idle, ready=1.
6. With I2C_CLK_STRETCH_EN, scl_in held 0 for 10 cycles in data2 -> that bit extends by 10 cycles and the byte completes at 154 cycles. Without the macro, completion stays at 144 cycles.
